// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and state encoding for the register-file writeback scheduler.
package regfile_ctrl_pkg;

    localparam int          NREG    = 32;
    localparam int          REG_AW  = 5;
    localparam int          XLEN    = 32;
    localparam int          SP_REG  = 2;
    localparam logic [31:0] SP_INIT = 32'h4000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping
// around to index 0. The grant is one-hot, or zero when nothing requests.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic w_found;

    // Two scans: first the indices >= ptr, then the wrapped indices below ptr
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && (PW'(i) >= ptr)) begin
                gnt[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                gnt[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owner of the register-file write port: zero-initialises x1..x31 (x2 gets
// the stack pointer) after reset, then arbitrates writeback requesters and
// keeps a pending-write scoreboard for issue-stage hazard stalls.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int              N_REQ   = 3,
    parameter int              XLEN    = regfile_ctrl_pkg::XLEN,
    parameter int              SP_REG  = regfile_ctrl_pkg::SP_REG,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(regfile_ctrl_pkg::SP_INIT)
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [REG_AW*N_REQ-1:0] req_rd,
    input  logic [XLEN*N_REQ-1:0]   req_wd,
    input  logic                    iss_valid,
    input  logic [REG_AW-1:0]       iss_rd,
    output logic                    iss_ready,
    input  logic [REG_AW-1:0]       rs1,
    input  logic [REG_AW-1:0]       rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rf_we,
    output logic [REG_AW-1:0]       rf_rd,
    output logic [XLEN-1:0]         rf_wd,
    output logic                    init_done
);

    localparam int                PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREG - 1);

    state_t            r_state, w_state_nxt;
    logic [REG_AW-1:0] r_init_ptr;
    logic [PW-1:0]     r_rr_ptr;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_rd;
    logic [XLEN-1:0]   r_rf_wd;
    logic              r_init_done;
    logic [NREG-1:0]   r_busy, w_busy_nxt;

    logic [N_REQ-1:0]  w_gnt;
    logic              w_run, w_accept, w_iss_fire;
    logic [PW-1:0]     w_sel_idx, w_rr_nxt;
    logic [REG_AW-1:0] w_sel_rd;
    logic [XLEN-1:0]   w_sel_wd;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    assign w_run      = (r_state == ST_RUN);
    assign req_ready  = w_run ? w_gnt : '0;
    assign w_accept   = |(req_valid & req_ready);
    // busy[0] is held at zero, so x0 is always ready once running
    assign iss_ready  = w_run & ~r_busy[iss_rd];
    assign w_iss_fire = iss_valid & iss_ready & (iss_rd != '0);
    assign rs1_busy   = w_run & r_busy[rs1];
    assign rs2_busy   = w_run & r_busy[rs2];

    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_wd      = r_rf_wd;
    assign init_done  = r_init_done;

    // Select the granted requester's payload and the pointer that follows it
    always_comb begin
        w_sel_idx = '0;
        w_sel_rd  = '0;
        w_sel_wd  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_idx = PW'(i);
                w_sel_rd  = req_rd[REG_AW*i +: REG_AW];
                w_sel_wd  = req_wd[XLEN*i +: XLEN];
            end
        end
        w_rr_nxt = (w_sel_idx == PW'(N_REQ - 1)) ? '0 : w_sel_idx + PW'(1);
    end

    // Next state: leave INIT once x31 has been put on the port
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_ptr == LAST_REG)
            w_state_nxt = ST_RUN;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_INIT;
        else          r_state <= w_state_nxt;
    end

    // Write port: init sweep, then the arbitrated writeback one cycle after accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_ptr  <= REG_AW'(1);
            r_rr_ptr    <= '0;
            r_rf_we     <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_wd     <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= r_init_done | w_run;
            if (!w_run) begin
                r_rf_we    <= 1'b1;
                r_rf_rd    <= r_init_ptr;
                r_rf_wd    <= (r_init_ptr == REG_AW'(SP_REG)) ? SP_INIT : '0;
                r_init_ptr <= r_init_ptr + REG_AW'(1);
            end else begin
                // An accepted x0 write consumes the grant but never reaches the file
                r_rf_we <= w_accept && (w_sel_rd != '0);
                if (w_accept) begin
                    r_rr_ptr <= w_rr_nxt;
                    if (w_sel_rd != '0) begin
                        r_rf_rd <= w_sel_rd;
                        r_rf_wd <= w_sel_wd;
                    end
                end
            end
        end
    end

    // Scoreboard update: clear on file capture first, then a new reservation wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_we)
            w_busy_nxt[r_rf_rd] = 1'b0;
        if (w_iss_fire)
            w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_busy <= '0;
        else          r_busy <= w_busy_nxt;
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed sequences with literal expectations,
// then constrained-random traffic checked every cycle against a behavioural model.
module tb_regfile_wb_scheduler;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [5*N-1:0]  req_rd = '0;
    logic [32*N-1:0] req_wd = '0;
    logic          iss_valid = 1'b0;
    logic [4:0]    iss_rd = '0;
    logic          iss_ready;
    logic [4:0]    rs1 = '0, rs2 = '0;
    logic          rs1_busy, rs2_busy;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_wd;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_wd(req_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_inits;      // init writes put on the port since reset
    bit         m_done;
    bit [31:0]  m_busy;
    int         m_rr;
    bit         m_we;
    bit [4:0]   m_rd;
    bit [31:0]  m_wd;
    int         m_last_acc;   // requester accepted at the most recent edge, -1 if none

    function automatic int grant_of(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int g;
        bit run;
        bit [31:0] nb;
        if (!reset_n) begin
            m_inits <= 0; m_done <= 0; m_busy <= '0; m_rr <= 0;
            m_we <= 0; m_rd <= '0; m_wd <= '0; m_last_acc <= -1;
        end else begin
            run = (m_inits == 31);
            nb  = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (run && iss_valid && iss_rd != 0 && !m_busy[iss_rd]) nb[iss_rd] = 1'b1;
            m_busy     <= nb;
            m_done     <= m_done | run;
            m_last_acc <= -1;
            if (!run) begin
                m_we    <= 1'b1;
                m_rd    <= 5'(m_inits + 1);
                m_wd    <= (m_inits + 1 == 2) ? 32'h4000 : 32'h0;
                m_inits <= m_inits + 1;
            end else begin
                g    = grant_of(req_valid, m_rr);
                m_we <= 1'b0;
                if (g >= 0) begin
                    m_last_acc <= g;
                    m_rr       <= (g + 1) % N;
                    if (req_rd[5*g +: 5] != 0) begin
                        m_we <= 1'b1;
                        m_rd <= req_rd[5*g +: 5];
                        m_wd <= req_wd[32*g +: 32];
                    end
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin : compare
        bit run;
        int g;
        logic [N-1:0] er;
        run = (m_inits == 31);
        er  = '0;
        if (run) begin
            g = grant_of(req_valid, m_rr);
            if (g >= 0) er[g] = 1'b1;
        end
        chk("m.req_ready", 32'(req_ready), 32'(er));
        chk("m.iss_ready", 32'(iss_ready), 32'(run && !m_busy[iss_rd]));
        chk("m.rs1_busy",  32'(rs1_busy),  32'(run && m_busy[rs1]));
        chk("m.rs2_busy",  32'(rs2_busy),  32'(run && m_busy[rs2]));
        chk("m.rf_we",     32'(rf_we),     32'(m_we));
        chk("m.rf_rd",     32'(rf_rd),     32'(m_rd));
        chk("m.rf_wd",     rf_wd,          m_wd);
        chk("m.init_done", 32'(init_done), 32'(m_done));
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.rf_we", 32'(rf_we), 0);
        chk("rst.init_done", 32'(init_done), 0);
        chk("rst.rf_rd", 32'(rf_rd), 0);

        // Requests and an x0 issue held through INIT; neither may be granted
        @(posedge clk); #1;
        reset_n   = 1'b1;
        req_valid = 3'b111;
        req_rd    = {5'd7, 5'd6, 5'd5};
        req_wd    = {32'h102, 32'h101, 32'h100};
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); @(negedge clk);
            chk("init.rf_we", 32'(rf_we), 1);
            chk("init.rf_rd", 32'(rf_rd), 32'(k));
            chk("init.rf_wd", rf_wd, (k == 2) ? 32'h4000 : 32'h0);
            if (k < 31) begin
                chk("init.req_ready", 32'(req_ready), 0);
                chk("init.iss_ready", 32'(iss_ready), 0);
            end
        end
        chk("init.done_late", 32'(init_done), 0);
        chk("rot.ready0", 32'(req_ready), 32'b001);

        // Rotation: rd 5,6,7,5 appear one cycle after each accept
        @(posedge clk); @(negedge clk);
        chk("init.done", 32'(init_done), 1);
        chk("rot.rd5", 32'(rf_rd), 5);
        chk("rot.ready1", 32'(req_ready), 32'b010);
        @(posedge clk); @(negedge clk);
        chk("rot.rd6", 32'(rf_rd), 6);
        chk("rot.wd6", rf_wd, 32'h101);
        chk("rot.ready2", 32'(req_ready), 32'b100);
        @(posedge clk); @(negedge clk);
        chk("rot.rd7", 32'(rf_rd), 7);
        @(posedge clk); @(negedge clk);
        chk("rot.rd5b", 32'(rf_rd), 5);
        chk("rot.ready1b", 32'(req_ready), 32'b010);
        @(posedge clk); #1;              // requester 1 accepted on this edge
        req_valid = '0;
        iss_valid = 1'b0;

        // Scoreboard: reserve x9, observe hazard, write back, observe clear
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        chk("sb.iss9", 32'(iss_ready), 1);
        @(posedge clk); #1;
        iss_valid = 1'b0; rs1 = 5'd9;
        @(negedge clk);
        chk("sb.rs1_busy", 32'(rs1_busy), 1);
        iss_valid = 1'b1;
        #1;
        chk("sb.reissue", 32'(iss_ready), 0);
        @(posedge clk); #1;
        iss_valid = 1'b0;
        req_valid = 3'b001; req_rd[4:0] = 5'd9; req_wd[31:0] = 32'h99;
        @(negedge clk);
        chk("sb.wb_ready", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("sb.wb_we", 32'(rf_we), 1);
        chk("sb.wb_rd", 32'(rf_rd), 9);
        chk("sb.still_busy", 32'(rs1_busy), 1);
        @(posedge clk); @(negedge clk);
        chk("sb.cleared", 32'(rs1_busy), 0);
        chk("sb.we_off", 32'(rf_we), 0);

        // x0 writeback: granted, no write, pointer still advances
        @(posedge clk); #1;
        req_valid = 3'b010; req_rd[9:5] = 5'd0; req_wd[63:32] = 32'hDEAD;
        @(negedge clk);
        chk("x0.ready", 32'(req_ready), 32'b010);
        @(posedge clk); #1;
        req_valid = 3'b110; req_rd[9:5] = 5'd4; req_rd[14:10] = 5'd11; req_wd[95:64] = 32'h22;
        @(negedge clk);
        chk("x0.no_we", 32'(rf_we), 0);
        chk("x0.rd_hold", 32'(rf_rd), 9);
        chk("x0.ptr_adv", 32'(req_ready), 32'b100);

        // Reset mid-burst with x3 reserved
        @(posedge clk); #1;
        req_valid = 3'b010;
        iss_valid = 1'b1; iss_rd = 5'd3;
        @(negedge clk);
        chk("mid.iss3", 32'(iss_ready), 1);
        @(posedge clk); #1;
        iss_valid = 1'b0; rs1 = 5'd3;
        req_valid = 3'b111; req_rd = {5'd14, 5'd13, 5'd12};
        @(negedge clk);
        chk("mid.busy3", 32'(rs1_busy), 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mid.rf_we", 32'(rf_we), 0);
        chk("mid.rf_rd", 32'(rf_rd), 0);
        chk("mid.rf_wd", rf_wd, 0);
        chk("mid.done", 32'(init_done), 0);
        chk("mid.busy_clr", 32'(rs1_busy), 0);
        chk("mid.ready", 32'(req_ready), 0);
        req_valid = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid.restart_we", 32'(rf_we), 1);
        chk("mid.restart_rd", 32'(rf_rd), 1);
        repeat (32) @(posedge clk);

        // Constrained-random traffic obeying the requester hold rule
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1500) reset_n = 1'b0;
            if (cyc == 1502) reset_n = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && i != m_last_acc)) begin
                    req_valid[i]       = ($urandom_range(0, 9) < 6);
                    req_rd[5*i +: 5]   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                                     : 5'($urandom_range(0, 7));
                    req_wd[32*i +: 32] = $urandom;
                end
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 8));
            rs2       = 5'($urandom_range(0, 8));
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
